// File: rtl/row_writer_pkg.sv
// rtl/row_writer_pkg.sv - shared CNN parameters and row writer state encoding
package row_writer_pkg;

  localparam int CNN_DATA_W  = 32;
  localparam int CNN_IM_SIZE = 32;
  localparam int CNN_ADDR_W  = 10;
  localparam int FRAME_W     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } row_state_t;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/row_writer_addr_gen.sv
// rtl/row_writer_addr_gen.sv - address, word, row and frame counters for row_writer
module row_addr_gen
  import row_writer_pkg::*;
#(
  parameter int IM_SIZE = CNN_IM_SIZE,
  parameter int ADDR_W  = CNN_ADDR_W,
  localparam int WCNT_W = cnt_width(IM_SIZE)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               issue,
  input  logic               wr_strobe,
  input  logic               row_end,
  output logic [ADDR_W-1:0]  addr,
  output logic [WCNT_W-1:0]  word_cnt,
  output logic [FRAME_W-1:0] frame_idx,
  output logic               frame_done
);

  localparam int ROW_W = cnt_width(IM_SIZE - 1);

  logic [ROW_W-1:0] row_cnt;

  // addr follows the registered strobe, so it steps the cycle after each write is presented.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr       <= '0;
      word_cnt   <= '0;
      row_cnt    <= '0;
      frame_idx  <= '0;
      frame_done <= 1'b0;
    end else if (clear) begin
      addr       <= '0;
      word_cnt   <= '0;
      row_cnt    <= '0;
      frame_idx  <= frame_idx + 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (wr_strobe)
        addr <= addr + 1'b1;
      if (issue)
        word_cnt <= word_cnt + 1'b1;
      if (row_end) begin
        word_cnt <= '0;
        if (row_cnt == ROW_W'(IM_SIZE - 1)) begin
          row_cnt    <= '0;
          frame_done <= 1'b1;
        end else begin
          row_cnt <= row_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/row_writer.sv
// rtl/row_writer.sv - serialises a parallel image row into sequential RAM writes
module row_writer
  import row_writer_pkg::*;
#(
  parameter int DATA_W  = CNN_DATA_W,
  parameter int IM_SIZE = CNN_IM_SIZE,
  parameter int ADDR_W  = CNN_ADDR_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           row_valid,
  input  logic [IM_SIZE-1:0][DATA_W-1:0] row_data,
  output logic                           row_ready,
  input  logic                           ram_hold,
  input  logic                           next_frame,
  output logic                           ram_wr_en,
  output logic [ADDR_W-1:0]              ram_addr,
  output logic [DATA_W-1:0]              ram_wdata,
  output logic                           row_done,
  output logic                           frame_done,
  output logic [FRAME_W-1:0]             frame_idx
);

  localparam int WCNT_W = cnt_width(IM_SIZE);

  row_state_t                     state;
  logic [IM_SIZE-1:0][DATA_W-1:0] sreg;
  logic [WCNT_W-1:0]              word_cnt;
  logic                           all_written;
  logic                           issue;
  logic                           row_end;

  assign row_ready   = (state == IDLE);
  assign all_written = (word_cnt == WCNT_W'(IM_SIZE));
  assign issue       = (state == SHIFT) && !ram_hold && !all_written && !next_frame;
  assign row_end     = (state == SHIFT) && all_written && !next_frame;

  // Highest element leaves first so a loader shifting in at index 0 rebuilds the row.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      sreg      <= '0;
      ram_wr_en <= 1'b0;
      ram_wdata <= '0;
      row_done  <= 1'b0;
    end else if (next_frame) begin
      state     <= IDLE;
      ram_wr_en <= 1'b0;
      row_done  <= 1'b0;
    end else begin
      ram_wr_en <= 1'b0;
      row_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (row_valid) begin
            sreg  <= row_data;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (row_end) begin
            state    <= DONE;
            row_done <= 1'b1;
          end else if (issue) begin
            ram_wr_en <= 1'b1;
            ram_wdata <= sreg[IM_SIZE-1];
            sreg      <= {sreg[IM_SIZE-2:0], {DATA_W{1'b0}}};
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  row_addr_gen #(
    .IM_SIZE (IM_SIZE),
    .ADDR_W  (ADDR_W)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .clear      (next_frame),
    .issue      (issue),
    .wr_strobe  (ram_wr_en),
    .row_end    (row_end),
    .addr       (ram_addr),
    .word_cnt   (word_cnt),
    .frame_idx  (frame_idx),
    .frame_done (frame_done)
  );

endmodule

// File: tb/tb_row_writer.sv
// tb/tb_row_writer.sv - scoreboard bench for row_writer
module tb_row_writer;

  localparam int DW = 32;
  localparam int IM = 32;
  localparam int AW = 10;

  typedef logic [IM-1:0][DW-1:0] row_t;
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          row_valid = 1'b0;
  logic          ram_hold = 1'b0;
  logic          next_frame = 1'b0;
  row_t          row_data = '0;
  logic          row_ready, ram_wr_en, row_done, frame_done;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [3:0]    frame_idx;

  int  n_cmp = 0, n_err = 0;
  int  cyc = 0, done_cyc = -1, frame_cnt = 0;
  int  wr_cyc[$];
  wr_t exp_wr[$];
  bit  exp_done[$];
  int  model_addr = 0, model_rows = 0, model_frame = 0;
  bit  hold_rand = 0, hold_force = 0, junk_en = 0;
  wr_t mon_e;
  bit  mon_f;

  row_writer #(.DATA_W(DW), .IM_SIZE(IM), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .row_valid  (row_valid),
    .row_data   (row_data),
    .row_ready  (row_ready),
    .ram_hold   (ram_hold),
    .next_frame (next_frame),
    .ram_wr_en  (ram_wr_en),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .row_done   (row_done),
    .frame_done (frame_done),
    .frame_idx  (frame_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: one frame is a contiguous 1024-word region written row by row, last element first.
  task automatic model_row(input row_t r);
    for (int k = IM - 1; k >= 0; k--) begin
      wr_t e;
      e.addr = AW'(model_addr);
      e.data = r[k];
      exp_wr.push_back(e);
      model_addr = (model_addr + 1) % (1 << AW);
    end
    model_rows++;
    exp_done.push_back(model_rows == IM);
    if (model_rows == IM) model_rows = 0;
  endtask

  task automatic model_clear(input bit new_frame);
    exp_wr.delete();
    exp_done.delete();
    model_addr = 0;
    model_rows = 0;
    model_frame = new_frame ? (model_frame + 1) % 16 : 0;
  endtask

  task automatic random_row(output row_t r);
    for (int k = 0; k < IM; k++) r[k] = $urandom;
  endtask

  task automatic send_row(input row_t r, output int acc);
    int n = 0;
    row_t junk;
    while (!row_ready && n < 500) begin
      if (junk_en && ($urandom % 3 == 0)) begin
        random_row(junk);
        row_data  = junk;
        row_valid = 1'b1;
      end else begin
        row_valid = 1'b0;
      end
      step();
      n++;
    end
    row_valid = 1'b0;
    check("ready_timeout", row_ready, 1'b1);
    row_data  = r;
    row_valid = 1'b1;
    model_row(r);
    step();
    row_valid = 1'b0;
    random_row(junk);
    row_data = junk;
    acc = cyc;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(row_ready && exp_wr.size() == 0 && exp_done.size() == 0) && n < 400) begin
      step();
      n++;
    end
    check("idle_timeout", n < 400, 1'b1);
  endtask

  task automatic pulse_next_frame();
    next_frame = 1'b1;
    step();
    next_frame = 1'b0;
    model_clear(1'b1);
    check("nf_frame_idx", frame_idx, model_frame);
    check("nf_ram_addr", ram_addr, 0);
    check("nf_wr_en", ram_wr_en, 0);
    check("nf_ready", row_ready, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_en"}, ram_wr_en, 0);
    check({tag, "_addr"}, ram_addr, 0);
    check({tag, "_wdata"}, ram_wdata, 0);
    check({tag, "_row_done"}, row_done, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_frame_idx"}, frame_idx, 0);
    check({tag, "_ready"}, row_ready, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_clear(1'b0);
    #1;
    check_all_zero("reset");
    step();
    step();
    rst = 1'b1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      ram_hold = hold_force | (hold_rand && ($urandom % 4 == 0));
    end
  end

  always @(negedge clk) begin
    if (ram_wr_en) begin
      wr_cyc.push_back(cyc);
      check("write_expected", exp_wr.size() != 0, 1'b1);
      if (exp_wr.size() != 0) begin
        mon_e = exp_wr.pop_front();
        check("wr_addr", ram_addr, mon_e.addr);
        check("wr_data", ram_wdata, mon_e.data);
      end
    end
    if (row_done) begin
      done_cyc = cyc;
      if (frame_done) frame_cnt++;
      check("row_done_expected", exp_done.size() != 0, 1'b1);
      if (exp_done.size() != 0) begin
        mon_f = exp_done.pop_front();
        check("frame_done", frame_done, mon_f);
        check("done_frame_idx", frame_idx, model_frame);
      end
    end else begin
      check("frame_done_alone", frame_done, 0);
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $finish;
  end

  initial begin
    row_t r;
    int   acc, fc;

    do_reset();

    // Counting row, unstalled latency
    for (int k = 0; k < IM; k++) r[k] = DW'(k + 1);
    wr_cyc.delete();
    send_row(r, acc);
    repeat (IM + 1) step();
    check("t1_row_done_now", row_done, 1'b1);
    check("t1_ready_in_done", row_ready, 0);
    step();
    check("t1_ready_back", row_ready, 1'b1);
    check("t1_done_cyc", done_cyc, acc + IM + 1);
    check("t1_nwrites", wr_cyc.size(), IM);
    if (wr_cyc.size() == IM) begin
      check("t1_first_wr_cyc", wr_cyc[0], acc + 1);
      check("t1_last_wr_cyc", wr_cyc[IM-1], acc + IM);
    end
    wait_idle();

    // Five-cycle stall after the 10th write
    do_reset();
    for (int k = 0; k < IM; k++) r[k] = DW'(k + 1);
    wr_cyc.delete();
    send_row(r, acc);
    repeat (10) step();
    hold_force = 1'b1;
    repeat (5) step();
    hold_force = 1'b0;
    wait_idle();
    check("t2_done_cyc", done_cyc, acc + IM + 6);
    check("t2_nwrites", wr_cyc.size(), IM);
    if (wr_cyc.size() == IM) begin
      check("t2_10th_wr_cyc", wr_cyc[9], acc + 10);
      check("t2_11th_wr_cyc", wr_cyc[10], acc + 16);
    end

    // A full frame of back-to-back random rows
    do_reset();
    fc = frame_cnt;
    for (int i = 0; i < IM; i++) begin
      random_row(r);
      send_row(r, acc);
    end
    wait_idle();
    check("t3_frame_pulses", frame_cnt - fc, 1);
    check("t3_addr_wrapped", ram_addr, 0);
    check("t3_frame_idx", frame_idx, 0);

    // Abort on the 16th write of row 3
    for (int i = 0; i < 2; i++) begin
      random_row(r);
      send_row(r, acc);
      wait_idle();
    end
    random_row(r);
    wr_cyc.delete();
    send_row(r, acc);
    repeat (15) step();
    pulse_next_frame();
    check("t4_writes_before_abort", wr_cyc.size(), 15);
    repeat (40) step();
    check("t4_no_more_writes", wr_cyc.size(), 15);
    random_row(r);
    send_row(r, acc);
    wait_idle();

    // Reset in the middle of a row
    random_row(r);
    send_row(r, acc);
    repeat (5) step();
    rst = 1'b0;
    model_clear(1'b0);
    #1;
    check_all_zero("midrow");
    step();
    rst = 1'b1;
    check("t6_ready_after_release", row_ready, 1'b1);
    random_row(r);
    send_row(r, acc);
    wait_idle();

    // frame_idx wraps after 16 requests
    for (int i = 0; i < 16; i++) pulse_next_frame();
    check("t5_frame_wrapped", frame_idx, 0);

    // Random traffic with stalls, ignored row_valid and random aborts
    hold_rand = 1'b1;
    junk_en   = 1'b1;
    for (int i = 0; i < 60; i++) begin
      random_row(r);
      send_row(r, acc);
      if ($urandom % 5 == 0) begin
        repeat ($urandom_range(0, 40)) step();
        pulse_next_frame();
      end else begin
        wait_idle();
      end
    end
    hold_rand = 1'b0;
    junk_en   = 1'b0;
    wait_idle();
    check("final_exp_wr_empty", exp_wr.size(), 0);
    check("final_frame_idx", frame_idx, model_frame);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/row_writer.md
ROW_WRITER -- requirements
Module: row_writer

Interface
REQ-001 Parameter DATA_W, default 32, width in bits of one pixel word.
REQ-002 Parameter IM_SIZE, default 32, words per row and rows per frame.
REQ-003 Parameter ADDR_W, default 10, RAM address width; IM_SIZE*IM_SIZE SHALL equal 2**ADDR_W.
REQ-004 Port clk  in  1  rising-edge clock.
REQ-005 Port rst  in  1  reset, asynchronous, active-low.
REQ-006 Port row_valid  in  1  row_data holds a complete row to be written.
REQ-007 Port row_data  in  IM_SIZE x DATA_W  parallel row, element 0..IM_SIZE-1.
REQ-008 Port row_ready  out  1  block can accept a row this cycle.
REQ-009 Port ram_hold  in  1  RAM cannot take a write this cycle.
REQ-010 Port next_frame  in  1  single-cycle request to start a new frame.
REQ-011 Port ram_wr_en  out  1  write strobe.
REQ-012 Port ram_addr  out  ADDR_W  write address.
REQ-013 Port ram_wdata  out  DATA_W  write data.
REQ-014 Port row_done  out  1  one-cycle pulse, row fully written.
REQ-015 Port frame_done  out  1  one-cycle pulse, last row of frame fully written.
REQ-016 Port frame_idx  out  4  current frame number.

Function
REQ-017 FSM states IDLE, SHIFT, DONE; row_ready SHALL be 1 only in IDLE.
REQ-018 IDLE: row_valid=1 SHALL capture row_data into an internal IM_SIZE-word shift register and move to SHIFT next cycle.
REQ-019 SHIFT, ram_hold=0: ram_wr_en=1, ram_wdata=next word, word counter +1; ram_addr SHALL advance by 1 after each write.
REQ-020 Write order SHALL be element IM_SIZE-1 first down to element 0, so a loader that shifts words in at index 0 reproduces the row unchanged.
REQ-021 SHIFT, ram_hold=1: ram_wr_en=0; counters, address and shift register SHALL hold.
REQ-022 After the IM_SIZE-th write, SHALL enter DONE for exactly one cycle with row_done=1, then return to IDLE.
REQ-023 Unstalled latency: accept at cycle N, writes at N+1..N+IM_SIZE, row_done at N+IM_SIZE+1, row_ready at N+IM_SIZE+2.
REQ-024 ram_addr SHALL wrap from 2**ADDR_W-1 to 0.
REQ-025 Row counter SHALL count completed rows; on the IM_SIZE-th row frame_done SHALL pulse in the same cycle as row_done, and the row counter SHALL return to 0.
REQ-026 next_frame=1 SHALL take priority over all other activity: abort any row in flight, ram_wr_en=0 that cycle, ram_addr=0, row counter=0, word counter=0, frame_idx+1 (wrap 15->0), state IDLE; no row_done/frame_done for the aborted row.
REQ-027 row_valid while not in IDLE SHALL be ignored; row_data SHALL not be sampled.
REQ-028 All outputs except row_ready SHALL be registered; row_ready SHALL be a decode of the state register.

Reset
REQ-029 rst=0 SHALL asynchronously force state IDLE, ram_wr_en=0, ram_addr=0, ram_wdata=0, row_done=0, frame_done=0, frame_idx=0, all counters and the shift register to 0.
REQ-030 Reset mid-row SHALL discard the row; after release row_ready=1 on the first cycle.

Structure
REQ-031 DATA_W, IM_SIZE, ADDR_W defaults and the state enumeration SHALL live in the shared CNN package.
REQ-032 Address, word, row and frame counters SHALL be one sub-module, row_addr_gen; the shift register and FSM stay in row_writer.

Verification
REQ-033 Reset, row_data[k]=k+1, pulse row_valid -> writes addr 0..31 with data 32,31,..,1; row_done at cycle 33; frame_done=0.
REQ-034 32 back-to-back rows -> addr 0..1023 contiguous, frame_done with row 32's row_done, ram_addr back at 0.
REQ-035 ram_hold=1 for 5 cycles after 10th write -> no writes for 5 cycles, 11th write carries element 21 at addr 10, row_done at cycle 38.
REQ-036 next_frame at 16th write of row 3 -> write suppressed that cycle, frame_idx 0->1, ram_addr=0, next row starts at addr 0, no row_done.
REQ-037 16 next_frame pulses -> frame_idx wraps 15->0.
REQ-038 rst=0 during SHIFT -> all outputs 0 immediately; row_valid pulsed after release writes from addr 0.
